// File: rtl/load_store_queue_if.sv
// Dispatch/commit/memory-side signal bundle for load_store_queue.
// The queue connects through the slave modport; the driving side uses master.
interface load_store_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          flush_in;
  logic          enq_valid_in;
  logic          enq_ready_out;
  logic          enq_is_store_in;
  logic [2:0]    enq_rob_ix_in;
  logic [31:0]   enq_addr_in;
  logic [31:0]   enq_data_in;
  logic          commit_valid_in;
  logic [2:0]    commit_rob_ix_in;
  logic          mem_ready_in;
  logic          mem_valid_out;
  logic          mem_load_or_store_out;
  logic [2:0]    mem_load_rob_ix_out;
  logic [31:0]   mem_load_addr_out;
  logic [31:0]   mem_store_addr_out;
  logic [31:0]   mem_store_data_out;
  logic          load_ack_in;
  logic [CW-1:0] count_out;

  modport master (
    output flush_in, enq_valid_in, enq_is_store_in, enq_rob_ix_in, enq_addr_in,
           enq_data_in, commit_valid_in, commit_rob_ix_in, mem_ready_in, load_ack_in,
    input  enq_ready_out, mem_valid_out, mem_load_or_store_out, mem_load_rob_ix_out,
           mem_load_addr_out, mem_store_addr_out, mem_store_data_out, count_out
  );

  modport slave (
    input  flush_in, enq_valid_in, enq_is_store_in, enq_rob_ix_in, enq_addr_in,
           enq_data_in, commit_valid_in, commit_rob_ix_in, mem_ready_in, load_ack_in,
    output enq_ready_out, mem_valid_out, mem_load_or_store_out, mem_load_rob_ix_out,
           mem_load_addr_out, mem_store_addr_out, mem_store_data_out, count_out
  );
endinterface

// File: rtl/load_store_queue.sv
// In-order load/store queue in front of the data memory unit: stores wait for
// ROB commit, loads hold the head from issue until the CDB acknowledges.
module load_store_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  load_store_queue_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t            state_q, state_d;
  logic [DEPTH-1:0]  valid_q, is_store_q, committed_q;
  logic [2:0]        rob_q  [DEPTH];
  logic [31:0]       addr_q [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q;
  logic              empty, full, enq_fire, eligible, issue, pop, enq_commit;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign enq_fire   = bus.enq_valid_in && !full;
  assign eligible   = !empty && (!is_store_q[head_q] || committed_q[head_q]);
  assign enq_commit = bus.enq_is_store_in && bus.commit_valid_in &&
                      (bus.enq_rob_ix_in == bus.commit_rob_ix_in);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (eligible && bus.mem_ready_in) begin
          issue = 1'b1;
          if (is_store_q[head_q]) pop = 1'b1;
          else                    state_d = WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        if (bus.load_ack_in) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)          state_q <= IDLE;
    else if (bus.flush_in) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q     <= '0;
      is_store_q  <= '0;
      committed_q <= '0;
      rob_q       <= '{default: '0};
      addr_q      <= '{default: '0};
      data_q      <= '{default: '0};
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else if (bus.flush_in) begin
      valid_q     <= '0;
      committed_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      if (bus.commit_valid_in) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (valid_q[PW'(i)] && is_store_q[PW'(i)] && (rob_q[PW'(i)] == bus.commit_rob_ix_in))
            committed_q[PW'(i)] <= 1'b1;
        end
      end
      // The tail slot is never valid when enqueue fires, so the commit
      // search above cannot collide with this write.
      if (enq_fire) begin
        valid_q[tail_q]     <= 1'b1;
        is_store_q[tail_q]  <= bus.enq_is_store_in;
        committed_q[tail_q] <= enq_commit;
        rob_q[tail_q]       <= bus.enq_rob_ix_in;
        addr_q[tail_q]      <= bus.enq_addr_in;
        data_q[tail_q]      <= bus.enq_data_in;
        tail_q              <= tail_q + PW'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (enq_fire && !pop)      count_q <= count_q + CW'(1);
      else if (!enq_fire && pop) count_q <= count_q - CW'(1);
    end
  end

  assign bus.enq_ready_out         = !full;
  assign bus.mem_valid_out         = issue;
  assign bus.count_out             = count_q;
  assign bus.mem_load_or_store_out = !empty && is_store_q[head_q];
  assign bus.mem_load_rob_ix_out   = empty ? '0 : rob_q[head_q];
  assign bus.mem_load_addr_out     = empty ? '0 : addr_q[head_q];
  assign bus.mem_store_addr_out    = empty ? '0 : addr_q[head_q];
  assign bus.mem_store_data_out    = empty ? '0 : data_q[head_q];
endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue (DEPTH=4): reset, load/store issue,
// commit gating, ordering, back-to-back, full/wrap and flush.
module tb_load_store_queue;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  int   errors = 0;
  int   checks = 0;

  load_store_queue_if #(.DEPTH(4)) bus ();
  load_store_queue #(.DEPTH(4)) dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

  always #5 clk_in = ~clk_in;

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic enq(input logic st, input logic [2:0] rob, input logic [31:0] a, input logic [31:0] d);
    bus.enq_is_store_in = st;
    bus.enq_rob_ix_in   = rob;
    bus.enq_addr_in     = a;
    bus.enq_data_in     = d;
    bus.enq_valid_in    = 1'b1;
    cyc();
    bus.enq_valid_in    = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    #1;
    checks++; if (bus.count_out !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", bus.count_out); end
    checks++; if (bus.enq_ready_out !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", bus.enq_ready_out); end
    checks++; if (bus.mem_valid_out !== 1'b0 || bus.mem_load_or_store_out !== 1'b0 || bus.mem_load_addr_out !== 32'd0 || bus.mem_store_data_out !== 32'd0)
      begin errors++; $display("FAIL rst_mem got=%b/%b/%h/%h exp=0", bus.mem_valid_out, bus.mem_load_or_store_out, bus.mem_load_addr_out, bus.mem_store_data_out); end
    cyc(); cyc();
    rst_in = 1'b1;
    // three loads queued, head issued, then reset while in WAIT_LOAD
    for (int i = 0; i < 3; i++) enq(1'b0, 3'(i), 32'h1000 + 32'(4*i), 32'd0);
    bus.mem_ready_in = 1'b1;
    #1;
    checks++; if (bus.mem_valid_out !== 1'b1) begin errors++; $display("FAIL rstwl_issue got=%b exp=1", bus.mem_valid_out); end
    cyc();
    checks++; if (bus.count_out !== 3'd3 || bus.mem_valid_out !== 1'b0) begin errors++; $display("FAIL rstwl_wait got=%0d/%b exp=3/0", bus.count_out, bus.mem_valid_out); end
    rst_in = 1'b0;
    #1;
    checks++; if (bus.count_out !== 3'd0 || bus.mem_valid_out !== 1'b0) begin errors++; $display("FAIL rstwl_async got=%0d/%b exp=0/0", bus.count_out, bus.mem_valid_out); end
    checks++; if (bus.mem_load_addr_out !== 32'd0) begin errors++; $display("FAIL rstwl_addr got=%h exp=0", bus.mem_load_addr_out); end
    cyc();
    rst_in = 1'b1;
    #1;
    checks++; if (bus.enq_ready_out !== 1'b1 || bus.mem_valid_out !== 1'b0) begin errors++; $display("FAIL rstwl_release got=%b/%b exp=1/0", bus.enq_ready_out, bus.mem_valid_out); end
    bus.mem_ready_in = 1'b0;
  endtask

  task automatic test_single_load();
    int pulses = 0;
    bus.mem_ready_in = 1'b1;
    enq(1'b0, 3'd5, 32'h8, 32'd0);
    checks++; if (bus.mem_valid_out !== 1'b1 || bus.mem_load_addr_out !== 32'h8 || bus.mem_load_rob_ix_out !== 3'd5 || bus.mem_load_or_store_out !== 1'b0)
      begin errors++; $display("FAIL load_issue got=%b/%h/%0d/%b exp=1/8/5/0", bus.mem_valid_out, bus.mem_load_addr_out, bus.mem_load_rob_ix_out, bus.mem_load_or_store_out); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (bus.mem_valid_out === 1'b1) pulses++;
      checks++; if (bus.mem_load_addr_out !== 32'h8 || bus.mem_load_rob_ix_out !== 3'd5) begin errors++; $display("FAIL load_hold got=%h/%0d exp=8/5", bus.mem_load_addr_out, bus.mem_load_rob_ix_out); end
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL load_single_pulse got=%0d extra exp=0", pulses); end
    bus.load_ack_in = 1'b1;
    cyc();
    bus.load_ack_in = 1'b0;
    #1;
    checks++; if (bus.count_out !== 3'd0 || bus.mem_load_addr_out !== 32'd0) begin errors++; $display("FAIL load_pop got=%0d/%h exp=0/0", bus.count_out, bus.mem_load_addr_out); end
  endtask

  task automatic test_store_gating();
    bus.mem_ready_in = 1'b1;
    enq(1'b1, 3'd2, 32'h4, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      bus.commit_valid_in  = (i == 2);
      bus.commit_rob_ix_in = 3'd3;
      #1;
      checks++; if (bus.mem_valid_out !== 1'b0 || bus.count_out !== 3'd1) begin errors++; $display("FAIL store_gate got=%b/%0d exp=0/1", bus.mem_valid_out, bus.count_out); end
      cyc();
      bus.commit_valid_in = 1'b0;
    end
    bus.commit_valid_in  = 1'b1;
    bus.commit_rob_ix_in = 3'd2;
    #1;
    checks++; if (bus.mem_valid_out !== 1'b0) begin errors++; $display("FAIL store_commit_cycle got=%b exp=0", bus.mem_valid_out); end
    cyc();
    bus.commit_valid_in = 1'b0;
    #1;
    checks++; if (bus.mem_valid_out !== 1'b1 || bus.mem_load_or_store_out !== 1'b1 || bus.mem_store_data_out !== 32'hDEADBEEF || bus.mem_store_addr_out !== 32'h4)
      begin errors++; $display("FAIL store_issue got=%b/%b/%h/%h exp=1/1/deadbeef/4", bus.mem_valid_out, bus.mem_load_or_store_out, bus.mem_store_data_out, bus.mem_store_addr_out); end
    cyc();
    checks++; if (bus.count_out !== 3'd0 || bus.mem_valid_out !== 1'b0) begin errors++; $display("FAIL store_pop got=%0d/%b exp=0/0", bus.count_out, bus.mem_valid_out); end
  endtask

  task automatic test_ordering();
    bus.mem_ready_in = 1'b1;
    enq(1'b1, 3'd1, 32'h10, 32'h1111);
    enq(1'b0, 3'd2, 32'h20, 32'd0);
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.mem_valid_out !== 1'b0 || bus.mem_load_or_store_out !== 1'b1) begin errors++; $display("FAIL order_block got=%b/%b exp=0/1", bus.mem_valid_out, bus.mem_load_or_store_out); end
      cyc();
    end
    bus.commit_valid_in  = 1'b1;
    bus.commit_rob_ix_in = 3'd1;
    cyc();
    bus.commit_valid_in = 1'b0;
    #1;
    checks++; if (bus.mem_valid_out !== 1'b1 || bus.mem_load_or_store_out !== 1'b1 || bus.mem_load_rob_ix_out !== 3'd1)
      begin errors++; $display("FAIL order_store got=%b/%b/%0d exp=1/1/1", bus.mem_valid_out, bus.mem_load_or_store_out, bus.mem_load_rob_ix_out); end
    cyc();
    checks++; if (bus.mem_valid_out !== 1'b1 || bus.mem_load_or_store_out !== 1'b0 || bus.mem_load_rob_ix_out !== 3'd2 || bus.mem_load_addr_out !== 32'h20)
      begin errors++; $display("FAIL order_load got=%b/%b/%0d/%h exp=1/0/2/20", bus.mem_valid_out, bus.mem_load_or_store_out, bus.mem_load_rob_ix_out, bus.mem_load_addr_out); end
    cyc();
    bus.load_ack_in = 1'b1;
    cyc();
    bus.load_ack_in = 1'b0;
    #1;
    checks++; if (bus.count_out !== 3'd0) begin errors++; $display("FAIL order_drain got=%0d exp=0", bus.count_out); end
  endtask

  task automatic test_enq_commit();
    bus.mem_ready_in     = 1'b1;
    bus.commit_valid_in  = 1'b1;
    bus.commit_rob_ix_in = 3'd6;
    enq(1'b1, 3'd6, 32'h40, 32'h4040);
    bus.commit_valid_in = 1'b0;
    #1;
    checks++; if (bus.mem_valid_out !== 1'b1 || bus.mem_load_or_store_out !== 1'b1 || bus.mem_store_data_out !== 32'h4040)
      begin errors++; $display("FAIL enqcommit_issue got=%b/%b/%h exp=1/1/4040", bus.mem_valid_out, bus.mem_load_or_store_out, bus.mem_store_data_out); end
    cyc();
    checks++; if (bus.count_out !== 3'd0) begin errors++; $display("FAIL enqcommit_pop got=%0d exp=0", bus.count_out); end
  endtask

  task automatic test_back_to_back();
    bus.mem_ready_in = 1'b0;
    enq(1'b1, 3'd3, 32'h200, 32'hA);
    enq(1'b1, 3'd4, 32'h204, 32'hB);
    for (int i = 3; i < 5; i++) begin
      bus.commit_valid_in  = 1'b1;
      bus.commit_rob_ix_in = 3'(i);
      cyc();
    end
    bus.commit_valid_in = 1'b0;
    bus.enq_is_store_in = 1'b0;
    bus.enq_rob_ix_in   = 3'd6;
    bus.enq_addr_in     = 32'h300;
    bus.enq_valid_in    = 1'b1;
    bus.mem_ready_in    = 1'b1;
    #1;
    checks++; if (bus.mem_valid_out !== 1'b1 || bus.mem_store_addr_out !== 32'h200) begin errors++; $display("FAIL b2b_first got=%b/%h exp=1/200", bus.mem_valid_out, bus.mem_store_addr_out); end
    cyc();
    bus.enq_valid_in = 1'b0;
    #1;
    checks++; if (bus.count_out !== 3'd2) begin errors++; $display("FAIL b2b_enq_pop_count got=%0d exp=2", bus.count_out); end
    checks++; if (bus.mem_valid_out !== 1'b1 || bus.mem_store_addr_out !== 32'h204 || bus.mem_store_data_out !== 32'hB)
      begin errors++; $display("FAIL b2b_second got=%b/%h/%h exp=1/204/b", bus.mem_valid_out, bus.mem_store_addr_out, bus.mem_store_data_out); end
    cyc();
    checks++; if (bus.count_out !== 3'd1 || bus.mem_valid_out !== 1'b1 || bus.mem_load_or_store_out !== 1'b0 || bus.mem_load_addr_out !== 32'h300)
      begin errors++; $display("FAIL b2b_load got=%0d/%b/%b/%h exp=1/1/0/300", bus.count_out, bus.mem_valid_out, bus.mem_load_or_store_out, bus.mem_load_addr_out); end
    cyc();
    bus.load_ack_in = 1'b1;
    cyc();
    bus.load_ack_in  = 1'b0;
    bus.mem_ready_in = 1'b0;
    #1;
    checks++; if (bus.count_out !== 3'd0) begin errors++; $display("FAIL b2b_drain got=%0d exp=0", bus.count_out); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] exp_addr;
    bus.mem_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) enq(1'b0, 3'(i), 32'h100 + 32'(4*i), 32'd0);
    checks++; if (bus.count_out !== 3'd4 || bus.enq_ready_out !== 1'b0) begin errors++; $display("FAIL full_state got=%0d/%b exp=4/0", bus.count_out, bus.enq_ready_out); end
    bus.enq_rob_ix_in = 3'd7;
    bus.enq_addr_in   = 32'h1FC;
    bus.enq_valid_in  = 1'b1;
    cyc();
    checks++; if (bus.count_out !== 3'd4) begin errors++; $display("FAIL full_reject got=%0d exp=4", bus.count_out); end
    bus.mem_ready_in = 1'b1;
    #1;
    checks++; if (bus.mem_valid_out !== 1'b1 || bus.mem_load_addr_out !== 32'h100) begin errors++; $display("FAIL full_issue got=%b/%h exp=1/100", bus.mem_valid_out, bus.mem_load_addr_out); end
    cyc();
    bus.mem_ready_in = 1'b0;
    bus.load_ack_in  = 1'b1;
    #1;
    checks++; if (bus.enq_ready_out !== 1'b0) begin errors++; $display("FAIL full_pop_no_slot got=%b exp=0", bus.enq_ready_out); end
    cyc();
    bus.load_ack_in  = 1'b0;
    bus.enq_valid_in = 1'b0;
    checks++; if (bus.count_out !== 3'd3) begin errors++; $display("FAIL full_after_pop got=%0d exp=3", bus.count_out); end
    bus.mem_ready_in = 1'b1;
    #1;
    checks++; if (bus.mem_valid_out !== 1'b1 || bus.mem_load_addr_out !== 32'h104) begin errors++; $display("FAIL full_issue2 got=%b/%h exp=1/104", bus.mem_valid_out, bus.mem_load_addr_out); end
    cyc();
    bus.mem_ready_in = 1'b0;
    bus.load_ack_in  = 1'b1;
    cyc();
    bus.load_ack_in = 1'b0;
    enq(1'b0, 3'd4, 32'h110, 32'd0);
    enq(1'b0, 3'd5, 32'h114, 32'd0);
    checks++; if (bus.count_out !== 3'd4) begin errors++; $display("FAIL wrap_refill got=%0d exp=4", bus.count_out); end
    for (int i = 0; i < 4; i++) begin
      exp_addr = 32'h108 + 32'(4*i);
      bus.mem_ready_in = 1'b1;
      #1;
      checks++; if (bus.mem_valid_out !== 1'b1 || bus.mem_load_addr_out !== exp_addr || bus.mem_load_rob_ix_out !== 3'(i + 2))
        begin errors++; $display("FAIL wrap_order[%0d] got=%b/%h/%0d exp=1/%h/%0d", i, bus.mem_valid_out, bus.mem_load_addr_out, bus.mem_load_rob_ix_out, exp_addr, i + 2); end
      cyc();
      bus.mem_ready_in = 1'b0;
      bus.load_ack_in  = 1'b1;
      cyc();
      bus.load_ack_in = 1'b0;
    end
    checks++; if (bus.count_out !== 3'd0) begin errors++; $display("FAIL wrap_drain got=%0d exp=0", bus.count_out); end
  endtask

  task automatic test_flush();
    bus.mem_ready_in = 1'b1;
    enq(1'b0, 3'd1, 32'h500, 32'd0);
    enq(1'b1, 3'd2, 32'h504, 32'h55);
    enq(1'b1, 3'd3, 32'h508, 32'h66);
    checks++; if (bus.count_out !== 3'd3 || bus.mem_valid_out !== 1'b0) begin errors++; $display("FAIL flush_setup got=%0d/%b exp=3/0", bus.count_out, bus.mem_valid_out); end
    bus.flush_in         = 1'b1;
    bus.enq_is_store_in  = 1'b0;
    bus.enq_rob_ix_in    = 3'd4;
    bus.enq_addr_in      = 32'h50C;
    bus.enq_valid_in     = 1'b1;
    bus.commit_valid_in  = 1'b1;
    bus.commit_rob_ix_in = 3'd2;
    bus.load_ack_in      = 1'b1;
    cyc();
    bus.flush_in        = 1'b0;
    bus.enq_valid_in    = 1'b0;
    bus.commit_valid_in = 1'b0;
    bus.load_ack_in     = 1'b0;
    #1;
    checks++; if (bus.count_out !== 3'd0 || bus.mem_valid_out !== 1'b0 || bus.mem_load_or_store_out !== 1'b0 || bus.enq_ready_out !== 1'b1)
      begin errors++; $display("FAIL flush_clear got=%0d/%b/%b/%b exp=0/0/0/1", bus.count_out, bus.mem_valid_out, bus.mem_load_or_store_out, bus.enq_ready_out); end
    enq(1'b0, 3'd5, 32'h600, 32'd0);
    checks++; if (bus.mem_valid_out !== 1'b1 || bus.mem_load_addr_out !== 32'h600) begin errors++; $display("FAIL flush_idle got=%b/%h exp=1/600", bus.mem_valid_out, bus.mem_load_addr_out); end
    cyc();
    bus.load_ack_in = 1'b1;
    cyc();
    bus.load_ack_in = 1'b0;
    checks++; if (bus.count_out !== 3'd0) begin errors++; $display("FAIL flush_final got=%0d exp=0", bus.count_out); end
  endtask

  initial begin
    bus.flush_in = 1'b0; bus.enq_valid_in = 1'b0; bus.enq_is_store_in = 1'b0;
    bus.enq_rob_ix_in = '0; bus.enq_addr_in = '0; bus.enq_data_in = '0;
    bus.commit_valid_in = 1'b0; bus.commit_rob_ix_in = '0;
    bus.mem_ready_in = 1'b0; bus.load_ack_in = 1'b0;
    test_reset();
    test_single_load();
    test_store_gating();
    test_ordering();
    test_enq_commit();
    test_back_to_back();
    test_full_wrap();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
